data_sram_resp: RTL
===================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, meaning the log2 of the word count of the internal data memory.
REQ-002 SHALL provide parameter LATENCY, default 2, legal range 1..15, meaning the cycles from request handshake to data_ok.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL provide port data_sram_req, input, 1 bit: the initiator requests a transfer.
REQ-006 SHALL provide port data_sram_wr, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL provide port data_sram_size, input, 2 bits: 0 = byte, 1 = half, 2 = word; informational only.
REQ-008 SHALL provide port data_sram_addr, input, 32 bits: byte address.
REQ-009 SHALL provide port data_sram_wstrb, input, 4 bits: byte-lane write enables.
REQ-010 SHALL provide port data_sram_wdata, input, 32 bits: write data.
REQ-011 SHALL provide port data_sram_addr_ok, output, 1 bit: the request is accepted this cycle.
REQ-012 SHALL provide port data_sram_data_ok, output, 1 bit: single-cycle response pulse.
REQ-013 SHALL provide port data_sram_rdata, output, 32 bits: read data, valid while data_ok = 1.

Function
REQ-014 SHALL implement a 2^ADDR_W x 32-bit memory indexed by addr[ADDR_W+1:2], ignoring higher address bits so that accesses wrap, and ignoring addr[1:0].
REQ-015 SHALL run an FSM with states IDLE, WAIT and RESP.
REQ-016 SHALL drive addr_ok combinationally as 1 when state is IDLE or RESP, and 0 in WAIT.
REQ-017 SHALL treat req & addr_ok at a rising edge as the handshake; at most one transfer is outstanding.
REQ-018 SHALL, on a write handshake, commit each wdata byte lane i with wstrb[i] = 1 at that edge; wstrb = 0 writes nothing but still receives data_ok.
REQ-019 SHALL, on a read handshake, capture the indexed word; a read that directly follows a write to the same word SHALL return the new data.
REQ-020 SHALL, on a handshake with LATENCY = 1, go to RESP; with LATENCY > 1, go to WAIT and load a 4-bit counter with LATENCY-2.
REQ-021 SHALL, in WAIT, decrement the counter each cycle and go to RESP when it is 0.
REQ-022 SHALL hold data_ok = 1 exactly in RESP, so data_ok rises LATENCY cycles after the handshake edge.
REQ-023 SHALL hold rdata equal to the captured word while in RESP; the value outside RESP is don't-care, and for writes it is don't-care.
REQ-024 SHALL, in RESP with a new handshake in the same cycle, retire the current response and start the new transfer per REQ-020 (back-to-back); without a handshake, go to IDLE.
REQ-025 SHALL produce a single data_ok per accepted request, in request order.
REQ-026 SHALL ignore req while addr_ok = 0; the initiator holds its request until accepted.

Reset
REQ-027 SHALL, on reset assertion, immediately force the state to IDLE, the counter to 0, data_ok to 0 and rdata to 0, with addr_ok = 1 once reset is released.
REQ-028 SHALL, on reset during WAIT or RESP, drop the pending response with no data_ok; a write committed before reset persists.
REQ-029 SHALL leave memory contents unaffected by reset.

Verification
REQ-030 SHALL cover a word write then read: write addr 0x10, wstrb 0xF, data 0xDEADBEEF, then read 0x10 -> data_ok 2 cycles after each handshake, rdata 0xDEADBEEF.
REQ-031 SHALL cover a byte-lane write: preload 0x11223344 at 0x20, write wstrb 0x2, data 0x0000AA00, then read -> rdata 0x1122AA44.
REQ-032 SHALL cover back-to-back reads: req held high for 3 reads at 0x0/0x4/0x8 with LATENCY = 1 -> addr_ok high every cycle, 3 consecutive data_ok pulses in order.
REQ-033 SHALL cover the latency sweep: LATENCY = 1, 2 and 15 -> data_ok exactly LATENCY cycles after the handshake, and addr_ok = 0 throughout WAIT.
REQ-034 SHALL cover wrap-around: with ADDR_W = 10, write 0x55 at 0x1000, then read 0x0000 -> rdata 0x00000055.
REQ-035 SHALL cover reset mid-WAIT: assert reset 1 cycle after a read handshake with LATENCY = 4 -> no data_ok, and the next request is accepted immediately after release.

Source files
------------

// File: rtl/data_sram_resp.sv
// Single-port data SRAM behind a req/addr_ok, data_ok handshake with fixed LATENCY.
// One transfer outstanding at a time; a new request may be accepted in the response cycle.
module data_sram_resp #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam state_t     HS_STATE = (LATENCY == 1) ? RESP : WAIT;
  localparam logic       HS_OK    = (LATENCY == 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        data_ok_q;
  logic [31:0] rdata_q;
  logic [31:0] mem [2**ADDR_W];

  logic              hs;
  logic [ADDR_W-1:0] idx;
  logic              unused_bits;

  // Size and the bits outside the word index do not affect the access.
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign idx               = data_sram_addr[ADDR_W+1:2];
  assign data_sram_addr_ok = (state_q != WAIT);
  assign hs                = data_sram_req & data_sram_addr_ok;
  assign data_sram_data_ok = data_ok_q;
  assign data_sram_rdata   = rdata_q;

  // Memory has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (hs && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if (hs) begin
            state_q   <= HS_STATE;
            cnt_q     <= CNT_INIT;
            data_ok_q <= HS_OK;
            if (!data_sram_wr) rdata_q <= mem[idx];
          end else begin
            state_q   <= IDLE;
            data_ok_q <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q   <= RESP;
            data_ok_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q   <= IDLE;
          data_ok_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
